pht_update_queue: RTL and testbench

Buffers branch-direction updates from the execution side and drains them into the PHT write port when that port does not conflict with a same-cycle predictor read. Each branch result is turned into a 2-bit saturating-counter update (index + new counter value), held in a circular FIFO, and written back in order. The block sits between the branch-resolution path (BranchResult: `phtIndex`, `phtPrevValue`, `execTaken`) and the banked PHT RAM used by the gshare predictor.

---
 rtl/pht_update_queue_if.sv | 31 +++
 rtl/pht_update_queue.sv | 108 ++++++++++
 tb/tb_pht_update_queue.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pht_update_queue_if.sv
// rtl/pht_update_queue_if.sv - branch-update, PHT read-snoop and PHT write-port bundle
interface pht_update_queue_if #(
    parameter int QUEUE_SIZE  = 32,
    parameter int INDEX_WIDTH = 10
);
    localparam int CW = $clog2(QUEUE_SIZE) + 1;

    logic                   updValid;
    logic [INDEX_WIDTH-1:0] updIndex;
    logic [1:0]             updPrevValue;
    logic                   updTaken;
    logic                   rdValid;
    logic [INDEX_WIDTH-1:0] rdIndex;
    logic                   wrEnable;
    logic [INDEX_WIDTH-1:0] wrIndex;
    logic [1:0]             wrValue;
    logic                   full;
    logic                   empty;
    logic                   dropped;
    logic [CW-1:0]          count;

    modport master (
        output updValid, updIndex, updPrevValue, updTaken, rdValid, rdIndex,
        input  wrEnable, wrIndex, wrValue, full, empty, dropped, count
    );

    modport slave (
        input  updValid, updIndex, updPrevValue, updTaken, rdValid, rdIndex,
        output wrEnable, wrIndex, wrValue, full, empty, dropped, count
    );
endinterface

// File: rtl/pht_update_queue.sv
// rtl/pht_update_queue.sv - in-order PHT update FIFO that yields to bank-conflicting reads (optional RSD_PHT_UPDATE_BYPASS_EN)
module pht_update_queue #(
    parameter int QUEUE_SIZE     = 32,
    parameter int INDEX_WIDTH    = 10,
    parameter int BANK_BIT_WIDTH = 1
) (
    input logic              clk,
    input logic              rst_n,
    pht_update_queue_if.slave bus
);
    localparam int PW = $clog2(QUEUE_SIZE);
    localparam int CW = PW + 1;
    localparam int EW = INDEX_WIDTH + 2;

    logic [EW-1:0]          mem_q [QUEUE_SIZE];
    logic [PW-1:0]          head_q, head_d;
    logic [PW-1:0]          tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d;

    logic                   full;
    logic                   empty;
    logic [1:0]             new_value;
    logic [EW-1:0]          entry_d;
    logic [EW-1:0]          head_entry;
    logic                   conflict;
    logic                   deq;
    logic                   enq;
    logic                   bypass;

    assign full       = (count_q == CW'(QUEUE_SIZE));
    assign empty      = (count_q == '0);
    assign head_entry = mem_q[head_q];

    // New counter value, head/bank conflict, dequeue/enqueue decisions and next pointers
    always_comb begin
        new_value = 2'd0;
        entry_d   = '0;
        conflict  = 1'b0;
        deq       = 1'b0;
        enq       = 1'b0;
        bypass    = 1'b0;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (bus.updTaken)
            new_value = (bus.updPrevValue == 2'd3) ? 2'd3 : bus.updPrevValue + 2'd1;
        else
            new_value = (bus.updPrevValue == 2'd0) ? 2'd0 : bus.updPrevValue - 2'd1;
        entry_d = {bus.updIndex, new_value};

        conflict = bus.rdValid &&
                   (bus.rdIndex[BANK_BIT_WIDTH-1:0] == head_entry[BANK_BIT_WIDTH+1:2]);
        deq      = !empty && !conflict;
`ifdef RSD_PHT_UPDATE_BYPASS_EN
        // An empty queue lets a non-conflicting update go straight to the write port
        bypass   = empty && bus.updValid &&
                   !(bus.rdValid &&
                     (bus.rdIndex[BANK_BIT_WIDTH-1:0] == bus.updIndex[BANK_BIT_WIDTH-1:0]));
`else
        bypass   = 1'b0;
`endif
        enq      = bus.updValid && (!full || deq) && !bypass;

        if (deq) head_d = head_q + PW'(1);
        if (enq) tail_d = tail_q + PW'(1);
        count_d = count_q + CW'(enq) - CW'(deq);
    end

    // Write port and drop pulse; index/value read as zero while the strobe is low
    always_comb begin
        bus.wrEnable = 1'b0;
        bus.wrIndex  = '0;
        bus.wrValue  = 2'd0;
        bus.dropped  = bus.updValid && full && !deq;
        if (bypass) begin
            bus.wrEnable = 1'b1;
            bus.wrIndex  = bus.updIndex;
            bus.wrValue  = new_value;
        end else if (deq) begin
            bus.wrEnable = 1'b1;
            bus.wrIndex  = head_entry[EW-1:2];
            bus.wrValue  = head_entry[1:0];
        end
    end

    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.count = count_q;

    // Pointer and occupancy registers; reset discards everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is not reset; stale contents are never visible because count gates reads
    always_ff @(posedge clk) begin
        if (enq) mem_q[tail_q] <= entry_d;
    end
endmodule

// File: tb/tb_pht_update_queue.sv
// tb/tb_pht_update_queue.sv - directed self-checking bench for pht_update_queue
module tb_pht_update_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pht_update_queue_if #(.QUEUE_SIZE(32), .INDEX_WIDTH(10)) bus ();

    pht_update_queue #(.QUEUE_SIZE(32), .INDEX_WIDTH(10), .BANK_BIT_WIDTH(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] nv(input logic [1:0] prev, input logic taken);
        if (taken) return (prev == 2'd3) ? 2'd3 : prev + 2'd1;
        return (prev == 2'd0) ? 2'd0 : prev - 2'd1;
    endfunction

    task automatic drive_upd(input logic v, input logic [9:0] idx, input logic [1:0] prev, input logic t);
        bus.updValid     = v;
        bus.updIndex     = idx;
        bus.updPrevValue = prev;
        bus.updTaken     = t;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push_get(input logic [9:0] idx, input logic [1:0] prev, input logic t,
                            output logic [9:0] gi, output logic [1:0] gv);
        bus.rdValid = 1'b0;
        drive_upd(1'b1, idx, prev, t);
        @(negedge clk);
        if (bus.wrEnable) begin
            gi = bus.wrIndex;
            gv = bus.wrValue;
            step();
            drive_upd(1'b0, 10'd0, 2'd0, 1'b0);
        end else begin
            step();
            drive_upd(1'b0, 10'd0, 2'd0, 1'b0);
            @(negedge clk);
            gi = bus.wrIndex;
            gv = bus.wrValue;
            step();
        end
    endtask

    logic [9:0] gi;
    logic [1:0] gv;
    int         got_idx [64];
    int         got_val [64];
    int         n_got;
    logic       drop_seen;
    logic       stale_seen;

    initial begin
        drive_upd(1'b0, 10'd0, 2'd0, 1'b0);
        bus.rdValid = 1'b0;
        bus.rdIndex = 10'd0;
        #2;
        check("rst_wrEnable", bus.wrEnable, 0);
        check("rst_wrIndex", bus.wrIndex, 0);
        check("rst_wrValue", bus.wrValue, 0);
        check("rst_full", bus.full, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_dropped", bus.dropped, 0);
        check("rst_count", bus.count, 0);
        step();
        rst_n = 1'b1;

        // Single update idx 0x05, prev 1, taken
        drive_upd(1'b1, 10'h005, 2'd1, 1'b1);
        @(negedge clk);
`ifdef RSD_PHT_UPDATE_BYPASS_EN
        check("single_byp_wrEnable", bus.wrEnable, 1);
        check("single_byp_wrIndex", bus.wrIndex, 10'h005);
        check("single_byp_wrValue", bus.wrValue, 2);
        step();
        drive_upd(1'b0, 10'd0, 2'd0, 1'b0);
        check("single_byp_count", bus.count, 0);
`else
        check("single_c1_wrEnable", bus.wrEnable, 0);
        step();
        drive_upd(1'b0, 10'd0, 2'd0, 1'b0);
        check("single_c2_count", bus.count, 1);
        @(negedge clk);
        check("single_c2_wrEnable", bus.wrEnable, 1);
        check("single_c2_wrIndex", bus.wrIndex, 10'h005);
        check("single_c2_wrValue", bus.wrValue, 2);
        step();
        check("single_c3_count", bus.count, 0);
`endif

        // Saturation corners
        push_get(10'h011, 2'd3, 1'b1, gi, gv);
        check("sat_up_idx", gi, 10'h011);
        check("sat_up_val", gv, 3);
        push_get(10'h012, 2'd0, 1'b0, gi, gv);
        check("sat_dn_val", gv, 0);
        push_get(10'h013, 2'd2, 1'b0, gi, gv);
        check("dec_val", gv, 1);
        check("sat_empty", bus.empty, 1);

        // Bank conflict holds the head
        bus.rdValid = 1'b1;
        bus.rdIndex = 10'h006;
        drive_upd(1'b1, 10'h004, 2'd1, 1'b0);
        step();
        drive_upd(1'b0, 10'd0, 2'd0, 1'b0);
        @(negedge clk);
        check("conf_wrEnable", bus.wrEnable, 0);
        check("conf_count", bus.count, 1);
        step();
        bus.rdIndex = 10'h007;
        @(negedge clk);
        check("conf_rel_wrEnable", bus.wrEnable, 1);
        check("conf_rel_wrIndex", bus.wrIndex, 10'h004);
        check("conf_rel_wrValue", bus.wrValue, 0);
        step();
        check("conf_rel_count", bus.count, 0);

        // Fill under a permanent conflict, then drop
        bus.rdValid = 1'b1;
        bus.rdIndex = 10'h000;
        for (int i = 0; i < 32; i++) begin
            drive_upd(1'b1, 10'(i * 2), 2'(i % 4), 1'(i % 2));
            step();
        end
        check("fill_full", bus.full, 1);
        check("fill_count", bus.count, 32);
        drive_upd(1'b1, 10'd64, 2'd1, 1'b1);
        @(negedge clk);
        check("drop_pulse", bus.dropped, 1);
        check("drop_wrEnable", bus.wrEnable, 0);
        step();
        check("drop_count", bus.count, 32);

        // Full with simultaneous dequeue accepts the incoming update
        bus.rdValid = 1'b0;
        drive_upd(1'b1, 10'h3FE, 2'd2, 1'b1);
        @(negedge clk);
        check("fullpass_dropped", bus.dropped, 0);
        check("fullpass_wrEnable", bus.wrEnable, 1);
        check("fullpass_wrIndex", bus.wrIndex, 0);
        check("fullpass_wrValue", bus.wrValue, nv(2'd0, 1'b0));
        step();
        drive_upd(1'b0, 10'd0, 2'd0, 1'b0);
        check("fullpass_count", bus.count, 32);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (k < 32) begin
                check($sformatf("drain_idx_%0d", k), bus.wrIndex, 32'(k * 2));
                check($sformatf("drain_val_%0d", k), bus.wrValue, nv(2'(k % 4), 1'(k % 2)));
            end else begin
                check("drain_last_idx", bus.wrIndex, 10'h3FE);
                check("drain_last_val", bus.wrValue, 3);
            end
            step();
        end
        check("drain_empty", bus.empty, 1);

        // Wrap-around ordering under random conflicts
        n_got = 0;
        drop_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.rdValid = 1'($urandom_range(0, 1));
            bus.rdIndex = 10'($urandom_range(0, 1023));
            drive_upd(1'b1, 10'(i), 2'(i % 4), 1'((i / 3) % 2));
            @(negedge clk);
            if (bus.dropped) drop_seen = 1'b1;
            if (bus.wrEnable && n_got < 64) begin
                got_idx[n_got] = int'(bus.wrIndex);
                got_val[n_got] = int'(bus.wrValue);
                n_got++;
            end
            step();
        end
        drive_upd(1'b0, 10'd0, 2'd0, 1'b0);
        for (int c = 0; c < 300; c++) begin
            if (bus.empty) break;
            bus.rdValid = 1'($urandom_range(0, 1));
            bus.rdIndex = 10'($urandom_range(0, 1023));
            @(negedge clk);
            if (bus.wrEnable && n_got < 64) begin
                got_idx[n_got] = int'(bus.wrIndex);
                got_val[n_got] = int'(bus.wrValue);
                n_got++;
            end
            step();
        end
        bus.rdValid = 1'b0;
        check("wrap_no_drop", drop_seen, 0);
        check("wrap_n_writes", n_got, 40);
        for (int k = 0; k < 40 && k < n_got; k++) begin
            check($sformatf("wrap_idx_%0d", k), got_idx[k], k);
            check($sformatf("wrap_val_%0d", k), got_val[k], 32'(nv(2'(k % 4), 1'((k / 3) % 2))));
        end

        // Asynchronous reset with entries in flight
        bus.rdValid = 1'b1;
        bus.rdIndex = 10'h000;
        for (int i = 0; i < 10; i++) begin
            drive_upd(1'b1, 10'(100 + i * 2), 2'd1, 1'b1);
            step();
        end
        drive_upd(1'b0, 10'd0, 2'd0, 1'b0);
        check("mid_count", bus.count, 10);
        bus.rdValid = 1'b0;
        #1;
        check("mid_pre_wrEnable", bus.wrEnable, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_count", bus.count, 0);
        check("arst_empty", bus.empty, 1);
        check("arst_wrEnable", bus.wrEnable, 0);
        check("arst_wrIndex", bus.wrIndex, 0);
        step();
        rst_n = 1'b1;
        stale_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.wrEnable) stale_seen = 1'b1;
            step();
        end
        check("arst_no_stale", stale_seen, 0);
        check("arst_final_count", bus.count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
